doodle_motion: RTL
==================

// Module: doodle_motion
// PURPOSE
//  Position and jump-distance generator for the doodle; it is the producer side of the doodle state machine.
//  - Consumes the one-hot state outputs (q_I/q_Up/q_Down/q_Done).
//  - Produces up_count, object_x and object_y, which feed back into the state machine's transitions.
//  - Moves the doodle at a divided step rate: vertical motion per state, horizontal motion from buttons with screen wrap.
//  - Sits between the state machine and the VGA sprite renderer.
// PARAMETERS
//  MOVE_DIV  250000  Clk cycles per movement step (step rate = Clk/MOVE_DIV)
//  STEP_V    1       pixels moved vertically per step
//  STEP_H    2       pixels moved horizontally per step
//  START_X   406     reset/idle centre x (on the start platform)
//  START_Y   477     reset/idle centre y (= platform top 490 - DOODLE_RADIUS)
// PORTS
//  Clk        in   1   system clock
//  Reset      in   1   asynchronous, active-high reset
//  q_I        in   1   state machine in idle
//  q_Up       in   1   state machine in rising phase
//  q_Down     in   1   state machine in falling phase
//  q_Done     in   1   state machine in game over
//  BtnL       in   1   move left (level, pre-debounced)
//  BtnR       in   1   move right (level, pre-debounced)
//  up_count   out  10  pixels risen since the current UP phase began
//  object_x   out  10  doodle centre x, screen coordinates 144..773
//  object_y   out  10  doodle centre y, screen coordinates 48..503
//  step       out  1   one-cycle pulse on every movement step (for debug/sound)
// BEHAVIOUR
//  Reset
//  - Async; all outputs take their reset values immediately: object_x=START_X, object_y=START_Y, up_count=0, step=0.
//  - Prescaler and up_prev are cleared. Reset mid-jump aborts the jump with no residue.
//  Prescaler
//  - div_cnt counts 0..MOVE_DIV-1, then wraps to 0.
//  - step=1 only in the cycle where div_cnt==MOVE_DIV-1. It free-runs in every state.
//  Jump start
//  - up_prev is q_Up registered. When q_Up & ~up_prev, up_count <= 0.
//  - That same cycle suppresses vertical motion; horizontal motion still applies.
//  I
//  - object_x<=START_X, object_y<=START_Y, up_count<=0 every cycle, so the doodle respawns after Ack.
//  UP, on step
//  - up_count <= up_count+STEP_V, saturating at 1023.
//  - object_y <= object_y-STEP_V, clamped at 48 (V_TOP+RADIUS). up_count still increments while clamped, so the jump always terminates.
//  DOWN, on step
//  - object_y <= object_y+STEP_V, clamped at 503. 503+13 > 515 triggers DONE in the state machine.
//  - up_count holds its value.
//  Horizontal (UP or DOWN only, on step)
//  - BtnL&~BtnR: x-=STEP_H. If the result would be < 144, x <= x-STEP_H+630 (wrap to the right).
//  - BtnR&~BtnL: x+=STEP_H. If the result would be > 773, x <= x+STEP_H-630 (wrap to the left).
//  - Both or neither pressed: x holds.
//  DONE
//  - All position outputs and up_count freeze.
//  Illegal state input (zero or more than one q_* high)
//  - Hold every register except the prescaler.
//  Arithmetic
//  - 10-bit unsigned. Compute the wrap and clamp tests in 11 bits to avoid underflow, e.g. 144-2.
//  Latency
//  - Registered outputs change one Clk after the step pulse. Each step moves at most one axis increment.
// STRUCTURE
//  Shared package/include (doodle_defs)
//  - H_LEFT=144, H_RIGHT=774, V_TOP=35, V_BOT=515, DOODLE_RADIUS=13.
//  - One-hot state encodings I/UP/DOWN/DONE, shared with the state machine.
//  Sub-module
//  - move_tick_gen (parameter DIV; outputs the step pulse).
//  - Everything else is one always block plus the up_prev edge detector.
// TESTING (MOVE_DIV=4 for simulation)
//  1. Reset asserted mid-UP, with x=300, y=200, up_count=57
//     -> same cycle: x=406, y=477, up_count=0, step=0.
//  2. q_Up for 10 steps from I
//     -> up_count=10, y=467, x=406.
//     -> Re-raise q_Up after DOWN: up_count=0 on the edge cycle, y unchanged that cycle.
//  3. q_Down with y=500, 6 steps
//     -> y=501, 502, 503, 503, 503, 503 (clamped); up_count unchanged.
//  4. x=145, BtnL held, q_Up, 1 step
//     -> x=773. Then x=772, BtnR held, 1 step -> x=774 wraps to 144.
//  5. BtnL=BtnR=1 during DOWN, 5 steps
//     -> x constant; y advances by 5.
//  6. q_Done asserted, and separately q_Up=q_Down=1
//     -> x, y, up_count frozen for 20 steps; step keeps pulsing every 4 cycles.

Source files
------------

// File: rtl/doodle_motion_pkg.sv
// Shared screen geometry and one-hot state encodings for the doodle motion
// datapath and the state machine that drives it.
package doodle_motion_pkg;

  localparam int H_LEFT        = 144;
  localparam int H_RIGHT       = 774;
  localparam int V_TOP         = 35;
  localparam int V_BOT         = 515;
  localparam int DOODLE_RADIUS = 13;

  localparam int X_MIN  = H_LEFT;
  localparam int X_MAX  = H_RIGHT - 1;
  localparam int X_SPAN = H_RIGHT - H_LEFT;
  localparam int Y_MIN  = V_TOP + DOODLE_RADIUS;
  localparam int Y_MAX  = 503;
  localparam int UP_MAX = 1023;

  typedef enum logic [3:0] {
    ST_I    = 4'b0001,
    ST_UP   = 4'b0010,
    ST_DOWN = 4'b0100,
    ST_DONE = 4'b1000
  } state_e;

endpackage

// File: rtl/doodle_motion_if.sv
// Link between the doodle state machine (master) and the motion generator
// (slave): one-hot state and buttons in, position and jump distance out.
interface doodle_motion_if;
  logic       q_I;
  logic       q_Up;
  logic       q_Down;
  logic       q_Done;
  logic       BtnL;
  logic       BtnR;
  logic [9:0] up_count;
  logic [9:0] object_x;
  logic [9:0] object_y;
  logic       step;

  modport master (
    output q_I, q_Up, q_Down, q_Done, BtnL, BtnR,
    input  up_count, object_x, object_y, step
  );

  modport slave (
    input  q_I, q_Up, q_Down, q_Done, BtnL, BtnR,
    output up_count, object_x, object_y, step
  );
endinterface

// File: rtl/doodle_motion_tick_gen.sv
// Free-running prescaler: pulses o_step for one cycle every DIV clocks.
module move_tick_gen #(
  parameter int DIV = 250000
) (
  input  logic Clk,
  input  logic Reset,
  output logic o_step
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_div_cnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_div_cnt <= '0;
    end else if (r_div_cnt == LAST) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + CW'(1);
    end
  end

  assign o_step = (r_div_cnt == LAST);

endmodule

// File: rtl/doodle_motion.sv
// Doodle position / jump-distance generator: vertical motion per state,
// horizontal motion from buttons with screen wrap, at the prescaled step rate.
module doodle_motion
  import doodle_motion_pkg::*;
#(
  parameter int MOVE_DIV = 250000,
  parameter int STEP_V   = 1,
  parameter int STEP_H   = 2,
  parameter int START_X  = 406,
  parameter int START_Y  = 477
) (
  input  logic           Clk,
  input  logic           Reset,
  doodle_motion_if.slave bus
);

  logic       w_step;
  logic [3:0] w_state;
  logic       w_legal;
  logic       w_jump_start;
  logic       r_up_prev;
  logic [9:0] r_x;
  logic [9:0] r_y;
  logic [9:0] r_up;

  move_tick_gen #(.DIV(MOVE_DIV)) u_tick (
    .Clk    (Clk),
    .Reset  (Reset),
    .o_step (w_step)
  );

  // Tests are done in 11 bits so that x-STEP_H near the left edge cannot underflow.
  function automatic logic [9:0] move_h(input logic [9:0] x, input logic l, input logic r);
    logic [10:0] t;
    t = {1'b0, x};
    if (l && !r) begin
      if (t < 11'(X_MIN + STEP_H)) t = t + 11'(X_SPAN - STEP_H);
      else                         t = t - 11'(STEP_H);
    end else if (r && !l) begin
      t = t + 11'(STEP_H);
      if (t > 11'(X_MAX)) t = t - 11'(X_SPAN);
    end
    return 10'(t);
  endfunction

  function automatic logic [9:0] clamp_up(input logic [9:0] y);
    if ({1'b0, y} < 11'(Y_MIN + STEP_V)) return 10'(Y_MIN);
    return y - 10'(STEP_V);
  endfunction

  function automatic logic [9:0] clamp_down(input logic [9:0] y);
    logic [10:0] t;
    t = {1'b0, y} + 11'(STEP_V);
    if (t > 11'(Y_MAX)) t = 11'(Y_MAX);
    return 10'(t);
  endfunction

  function automatic logic [9:0] sat_up(input logic [9:0] u);
    logic [10:0] t;
    t = {1'b0, u} + 11'(STEP_V);
    if (t > 11'(UP_MAX)) t = 11'(UP_MAX);
    return 10'(t);
  endfunction

  assign w_state      = {bus.q_Done, bus.q_Down, bus.q_Up, bus.q_I};
  assign w_legal      = $onehot(w_state);
  assign w_jump_start = bus.q_Up && !r_up_prev;

  // Edge detector freezes along with the datapath when the state input is illegal.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_up_prev <= 1'b0;
    end else if (w_legal) begin
      r_up_prev <= bus.q_Up;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_x  <= 10'(START_X);
      r_y  <= 10'(START_Y);
      r_up <= '0;
    end else begin
      case (w_state)
        ST_I: begin
          r_x  <= 10'(START_X);
          r_y  <= 10'(START_Y);
          r_up <= '0;
        end
        ST_UP: begin
          if (w_jump_start) begin
            r_up <= '0;
          end else if (w_step) begin
            r_up <= sat_up(r_up);
            r_y  <= clamp_up(r_y);
          end
          if (w_step) r_x <= move_h(r_x, bus.BtnL, bus.BtnR);
        end
        ST_DOWN: begin
          if (w_step) begin
            r_y <= clamp_down(r_y);
            r_x <= move_h(r_x, bus.BtnL, bus.BtnR);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.up_count = r_up;
  assign bus.object_x = r_x;
  assign bus.object_y = r_y;
  assign bus.step     = w_step;

endmodule
